cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Completion-side counterpart of the reservation station. It collects finished results from the
//  ALU, LD, ST, FP1 and FP2 functional units and buffers them per unit. Each cycle it grants one
//  result and broadcasts its tag and value on the common data bus (CDB). The RS, map table and
//  ROB snoop the CDB to wake up waiting operands (T1/T2.ready) and mark the tag complete.
// PARAMETERS
//  N_FU       5   number of FU completion ports; index 0=ALU 1=LD 2=ST 3=FP1 4=FP2
//  TAG_W      6   physical-register tag width; tag 0 = "no destination"
//  XLEN       32  result value width
//  BUF_DEPTH  2   per-FU completion FIFO depth (power of 2, >=2)
// PORTS
//  clock        in   1            single clock, all state on rising edge
//  reset        in   1            asynchronous, active-low reset (asserted when 0)
//  squash       in   1            mispredict flush; synchronous, active-high
//  fu_valid     in   N_FU         FU i presents a completed result
//  fu_tag       in   N_FU*TAG_W   destination tag per FU (slice i = FU i)
//  fu_value     in   N_FU*XLEN    result value per FU
//  fu_ready     out  N_FU         FU i result accepted this cycle if fu_valid[i] && fu_ready[i]
//  cdb_valid    out  1            CDB broadcast valid
//  cdb_tag      out  TAG_W        broadcast tag
//  cdb_value    out  XLEN         broadcast value
//  cdb_fu       out  3            index of FU whose result is broadcast
// BEHAVIOUR
//  - Reset (reset==0, async): all FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0,
//    cdb_fu=0, fu_ready=all 1 once state is cleared. Reset wins over squash and all pushes.
//  - Per-FU FIFO: push on fu_valid[i]&&fu_ready[i]. fu_ready[i] = (count_i < BUF_DEPTH); it
//    depends only on registered count, never on same-cycle pop (no comb path from grant).
//  - Arbiter: round-robin over FIFOs that are non-empty at the start of the cycle. Search starts
//    at rr_ptr and proceeds upward modulo N_FU. The winner is popped at the edge.
//    rr_ptr <= (winner+1) mod N_FU. rr_ptr is unchanged if nothing is granted.
//  - Output registered: winner's head entry appears on cdb_* on the cycle after the grant edge.
//    cdb_valid=0 when no FIFO is non-empty. cdb_tag/value/fu hold their last value when invalid.
//  - Latency: FU handshake at edge k -> earliest cdb_valid at cycle following edge k+1
//    (1 cycle in FIFO + 1 output register). Exactly one broadcast per cycle max.
//  - Push and pop on same FIFO in the same cycle: both happen, count unchanged; legal at any count
//    < BUF_DEPTH. A full FIFO accepts no push, even when popping.
//  - Tag 0 entries (e.g. stores) are queued and broadcast normally with cdb_valid=1, cdb_tag=0.
//    Consumers ignore tag 0 for wakeup; the ROB uses cdb_fu for completion.
//  - squash=1 at edge: all FIFOs emptied, same-cycle pushes dropped, cdb_valid<=0.
//    rr_ptr is kept. fu_ready is all 1 on the next cycle.
//  - FIFO pointers wrap modulo BUF_DEPTH. count is BUF_DEPTH+1 states wide (no full/empty alias).
//  - No X on outputs after reset. fu_tag/fu_value are sampled only on an accepted push.
// TESTING
//  1 Reset release, ALU push tag=5 val=0x10 at edge k -> cdb_valid=1, tag=5, val=0x10,
//    cdb_fu=0 after edge k+1. cdb_valid=0 the following cycle.
//  2 All 5 FUs push tags 1..5 in the same cycle, rr_ptr=0 -> broadcasts in order 1,2,3,4,5 on
//    5 consecutive cycles. rr_ptr ends at 0 (wrap).
//  3 FP1 pushes tags 8,9,10 on back-to-back cycles while ALU is kept non-empty -> FIFO3 fills.
//    fu_ready[3]=0 with count=2. The third push is held until a pop, and no tag is lost or duplicated.
//  4 rr_ptr=3, FIFOs 0 and 4 non-empty -> FU4 granted first, then FU0. rr_ptr becomes 1.
//  5 Three entries queued, squash=1 with a simultaneous LD push -> next cycle cdb_valid=0 and all
//    fu_ready=1. The squashed tags are never broadcast.
//  6 Assert reset low mid-burst (async, between edges) -> cdb_valid=0 immediately. After release,
//    the first new push broadcasts with 1-cycle FIFO latency and no stale data.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU completion handshake plus CDB broadcast bundle.
interface cdb_arbiter_if #(parameter int N_FU = 5, parameter int TAG_W = 6, parameter int XLEN = 32);
  logic [N_FU-1:0]       fu_valid;
  logic [N_FU-1:0]       fu_ready;
  logic [N_FU*TAG_W-1:0] fu_tag;
  logic [N_FU*XLEN-1:0]  fu_value;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [XLEN-1:0]       cdb_value;
  logic [2:0]            cdb_fu;
  modport master (output fu_valid, fu_tag, fu_value, input fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu);
  modport slave (input fu_valid, fu_tag, fu_value, output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU completion FIFOs with round-robin grant onto a registered common data bus.
module cdb_arbiter #(
  parameter int N_FU      = 5,
  parameter int TAG_W     = 6,
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          squash_i,
  cdb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = TAG_W + XLEN;
  logic [CW-1:0]    cnt_q [N_FU];
  logic [CW-1:0]    cnt_d [N_FU];
  logic [PW-1:0]    wp_q [N_FU];
  logic [PW-1:0]    wp_d [N_FU];
  logic [PW-1:0]    rp_q [N_FU];
  logic [PW-1:0]    rp_d [N_FU];
  logic [EW-1:0]    mem_q [N_FU][BUF_DEPTH];
  logic [N_FU-1:0]  rdy, push, pop;
  logic [2:0]       rr_q, rr_d, win, j;
  logic             gnt;
  logic [EW-1:0]    head;
  logic             cv_q, cv_d;
  logic [TAG_W-1:0] ct_q, ct_d;
  logic [XLEN-1:0]  cval_q, cval_d;
  logic [2:0]       cf_q, cf_d;
  // first non-empty FIFO at or above rr_q, wrapping
  always_comb begin
    gnt = 1'b0;
    win = '0;
    j   = '0;
    for (int k = 0; k < N_FU; k++) begin
      j = 3'((32'(rr_q) + k) % N_FU);
      if (!gnt && cnt_q[j] != '0) begin
        gnt = 1'b1;
        win = j;
      end
    end
  end
  // ready comes from registered count only, so no path from the grant back to the FUs
  always_comb begin
    rdy  = '0;
    push = '0;
    pop  = '0;
    for (int i = 0; i < N_FU; i++) begin
      rdy[i]   = cnt_q[i] < CW'(BUF_DEPTH);
      push[i]  = bus.fu_valid[i] && rdy[i] && !squash_i;
      pop[i]   = gnt && !squash_i && win == 3'(i);
      cnt_d[i] = squash_i ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      wp_d[i]  = squash_i ? '0 : wp_q[i] + PW'(push[i]);
      rp_d[i]  = squash_i ? '0 : rp_q[i] + PW'(pop[i]);
    end
  end
  assign head   = mem_q[win][rp_q[win]];
  assign cv_d   = gnt && !squash_i;
  assign ct_d   = cv_d ? head[EW-1:XLEN] : ct_q;
  assign cval_d = cv_d ? head[XLEN-1:0] : cval_q;
  assign cf_d   = cv_d ? win : cf_q;
  assign rr_d   = cv_d ? 3'((32'(win) + 1) % N_FU) : rr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '{default: '0};
      wp_q   <= '{default: '0};
      rp_q   <= '{default: '0};
      rr_q   <= '0;
      cv_q   <= 1'b0;
      ct_q   <= '0;
      cval_q <= '0;
      cf_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      rr_q   <= rr_d;
      cv_q   <= cv_d;
      ct_q   <= ct_d;
      cval_q <= cval_d;
      cf_q   <= cf_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FU; i++)
      if (push[i]) mem_q[i][wp_q[i]] <= {bus.fu_tag[i*TAG_W +: TAG_W], bus.fu_value[i*XLEN +: XLEN]};
  end
  assign bus.fu_ready  = rdy;
  assign bus.cdb_valid = cv_q;
  assign bus.cdb_tag   = ct_q;
  assign bus.cdb_value = cval_q;
  assign bus.cdb_fu    = cf_q;
endmodule
